// File: rtl/ss_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package ss_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    YIELD = 2'd2
  } arb_state_e;

  localparam int BCD_W      = 4;
  localparam int NUM_DIGITS = 4;
  localparam int WORD_W     = BCD_W * NUM_DIGITS;

  localparam logic [BCD_W-1:0] BLANK_CODE_DEF = 4'hF;

  // Replicate one BCD nibble across every digit of a display word.
  function automatic logic [WORD_W-1:0] fill_word(input logic [BCD_W-1:0] code);
    return {NUM_DIGITS{code}};
  endfunction

endpackage

// File: rtl/ss_display_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer,
// wrapping, as a one-hot grant, an index and a valid flag.
module rr_arbiter
  import ss_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic               valid_o
);

  // Scan from the pointer upward, keep the first active request.
  always_comb begin
    int cand;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr_i) + k) % NUM_REQ;
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = PTR_W'(cand);
        gnt_o   = NUM_REQ'(1) << cand;
      end
    end
  end

endmodule

// File: rtl/ss_display_arbiter.sv
// Shares one 4-digit seven-segment display between NUM_REQ requesters with
// round-robin ownership, a minimum hold before pre-emption and a maximum
// slot once someone else is waiting.
// Optional build macro: SS_ARB_BLINK_EN adds the BlinkMask input and a
// free-running blink counter that blanks selected digits.
//
//   state | meaning
//   IDLE  | no owner, digits blanked, waiting for any request
//   OWN   | one requester drives the digits, slot timer running
//   YIELD | one-cycle handover, grant dropped, digits hold last value
module ss_display_arbiter
  import ss_pkg::*;
#(
  parameter int               NUM_REQ    = 3,
  parameter int               MIN_HOLD   = 1000,
  parameter int               MAX_SLOT   = 100000,
  parameter logic [BCD_W-1:0] BLANK_CODE = BLANK_CODE_DEF
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [NUM_REQ-1:0]        Req,
  input  logic [WORD_W*NUM_REQ-1:0] Data,
`ifdef SS_ARB_BLINK_EN
  input  logic [NUM_DIGITS-1:0]     BlinkMask,
`endif
  output logic [NUM_REQ-1:0]        Grant,
  output logic [BCD_W-1:0]          BCD3,
  output logic [BCD_W-1:0]          BCD2,
  output logic [BCD_W-1:0]          BCD1,
  output logic [BCD_W-1:0]          BCD0,
  output logic                      Busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_SLOT + 1);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_SLOT);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic                busy_q,  busy_d;
  logic [WORD_W-1:0]   bcd_q,   bcd_d;
  logic [CNT_W-1:0]    hold_q,  hold_d;
  logic [PTR_W-1:0]    ptr_q,   ptr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;

  logic [NUM_REQ-1:0]  win_gnt;
  logic [PTR_W-1:0]    win_idx;
  logic                win_valid;

  logic [WORD_W-1:0]   owner_word;
  logic [WORD_W-1:0]   load_word;
  logic [CNT_W-1:0]    hold_inc;
  logic [PTR_W-1:0]    ptr_after_owner;
  logic                owner_active;
  logic                others_pending;
  logic                slot_expired;

  // The pointer already points past the previous owner while in YIELD,
  // so the same pick serves both IDLE and the handover.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req_i   (Req),
    .ptr_i   (ptr_q),
    .gnt_o   (win_gnt),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

  assign owner_word      = Data[int'(owner_q)*WORD_W +: WORD_W];
  assign owner_active    = Req[owner_q];
  assign others_pending  = |(Req & ~grant_q);
  assign hold_inc        = (hold_q == CNT_MAX) ? hold_q : hold_q + CNT_W'(1);
  assign ptr_after_owner = (owner_q == PTR_LAST) ? '0 : owner_q + PTR_W'(1);
  assign slot_expired    = (int'(hold_q) >= MAX_SLOT - 1) && (int'(hold_q) >= MIN_HOLD);

`ifdef SS_ARB_BLINK_EN
  logic [23:0] blink_cnt_q;

  // Free-running blink period counter; MSB gives the blank phase.
  always_ff @(posedge Clk) begin
    if (Reset) blink_cnt_q <= '0;
    else       blink_cnt_q <= blink_cnt_q + 24'd1;
  end

  // Blank masked digits during the blink phase, sampled alongside Data.
  always_comb begin
    load_word = owner_word;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (blink_cnt_q[23] && BlinkMask[d]) load_word[d*BCD_W +: BCD_W] = BLANK_CODE;
    end
  end
`else
  assign load_word = owner_word;
`endif

  // State and output registers; reset aborts any slot on the same edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      bcd_q   <= fill_word(BLANK_CODE);
      hold_q  <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      bcd_q   <= bcd_d;
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    bcd_d   = bcd_q;
    hold_d  = hold_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;

    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d = OWN;
          grant_d = win_gnt;
          owner_d = win_idx;
          busy_d  = 1'b1;
          hold_d  = '0;
        end
      end

      OWN: begin
        bcd_d  = load_word;
        hold_d = hold_inc;
        // Voluntary release is always honoured; pre-emption needs the slot used up.
        if (!owner_active || (others_pending && slot_expired)) begin
          state_d = YIELD;
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = ptr_after_owner;
        end
      end

      YIELD: begin
        if (win_valid) begin
          state_d = OWN;
          grant_d = win_gnt;
          owner_d = win_idx;
          busy_d  = 1'b1;
          hold_d  = '0;
        end else begin
          state_d = IDLE;
          bcd_d   = fill_word(BLANK_CODE);
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign Grant = grant_q;
  assign Busy  = busy_q;
  assign BCD3  = bcd_q[4*BCD_W-1:3*BCD_W];
  assign BCD2  = bcd_q[3*BCD_W-1:2*BCD_W];
  assign BCD1  = bcd_q[2*BCD_W-1:1*BCD_W];
  assign BCD0  = bcd_q[1*BCD_W-1:0];

endmodule
